// File: rtl/forwarding_hazard_unit.sv
// Operand-forwarding and load-use hazard control for a 5-stage RV32IM pipeline.
// Tracks destination info of the EX and MEM instructions; forward enables are registered for the instruction entering EX.
module forwarding_hazard_unit #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  CLK,
   input  logic                  RESETN,
   input  logic                  STALL_IN,
   input  logic                  FLUSH,
   input  logic                  ID_VALID,
   input  logic [REG_ADDR_W-1:0] ID_RS1,
   input  logic [REG_ADDR_W-1:0] ID_RS2,
   input  logic                  ID_USES_RS1,
   input  logic                  ID_USES_RS2,
   input  logic [REG_ADDR_W-1:0] ID_RD,
   input  logic                  ID_REG_WRITE,
   input  logic                  ID_MEM_READ,
   output logic                  LOAD_STALL,
   output logic [1:0]            MEM_FORWARD_EN,
   output logic [1:0]            WB_FORWARD_EN
);

   // EX slot keeps all fields; the MEM slot only needs "is a writer" and rd.
   // The WB instruction needs no storage: its forwarding match is decided one
   // edge earlier against the MEM slot and captured in the registered enables.
   logic                  ex_vld_q, ex_vld_d;
   logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
   logic                  ex_we_q, ex_we_d;
   logic                  ex_ld_q, ex_ld_d;
   logic                  mem_wr_q, mem_wr_d;
   logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
   logic [1:0]            mem_fwd_q, mem_fwd_d;
   logic [1:0]            wb_fwd_q, wb_fwd_d;

   logic       ex_writer;
   logic [1:0] uses;
   logic [1:0] mem_hit;
   logic [1:0] wb_hit;
   logic       load_stall;
   logic       bubble;

   assign uses      = {ID_USES_RS2, ID_USES_RS1};
   assign ex_writer = ex_vld_q && ex_we_q && (ex_rd_q != '0);

   always_comb begin
      mem_hit[0] = uses[0] && ex_writer && (ID_RS1 == ex_rd_q);
      mem_hit[1] = uses[1] && ex_writer && (ID_RS2 == ex_rd_q);
      wb_hit[0]  = uses[0] && mem_wr_q && (ID_RS1 == mem_rd_q);
      wb_hit[1]  = uses[1] && mem_wr_q && (ID_RS2 == mem_rd_q);
   end

   // A load in EX cannot forward yet; FLUSH wins since the consumer is squashed anyway.
   assign load_stall = ID_VALID && !FLUSH && ex_writer && ex_ld_q && (mem_hit != 2'b00);
   assign bubble     = FLUSH || load_stall || !ID_VALID;

   always_comb begin
      ex_vld_d  = ex_vld_q;
      ex_rd_d   = ex_rd_q;
      ex_we_d   = ex_we_q;
      ex_ld_d   = ex_ld_q;
      mem_wr_d  = mem_wr_q;
      mem_rd_d  = mem_rd_q;
      mem_fwd_d = mem_fwd_q;
      wb_fwd_d  = wb_fwd_q;
      if (!STALL_IN) begin
         mem_wr_d = ex_writer;
         mem_rd_d = ex_rd_q;
         if (bubble) begin
            ex_vld_d  = 1'b0;
            ex_rd_d   = '0;
            ex_we_d   = 1'b0;
            ex_ld_d   = 1'b0;
            mem_fwd_d = 2'b00;
            wb_fwd_d  = 2'b00;
         end else begin
            ex_vld_d  = 1'b1;
            ex_rd_d   = ID_RD;
            ex_we_d   = ID_REG_WRITE;
            ex_ld_d   = ID_MEM_READ;
            mem_fwd_d = mem_hit;
            wb_fwd_d  = wb_hit & ~mem_hit;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         ex_vld_q  <= 1'b0;
         ex_rd_q   <= '0;
         ex_we_q   <= 1'b0;
         ex_ld_q   <= 1'b0;
         mem_wr_q  <= 1'b0;
         mem_rd_q  <= '0;
         mem_fwd_q <= 2'b00;
         wb_fwd_q  <= 2'b00;
      end else begin
         ex_vld_q  <= ex_vld_d;
         ex_rd_q   <= ex_rd_d;
         ex_we_q   <= ex_we_d;
         ex_ld_q   <= ex_ld_d;
         mem_wr_q  <= mem_wr_d;
         mem_rd_q  <= mem_rd_d;
         mem_fwd_q <= mem_fwd_d;
         wb_fwd_q  <= wb_fwd_d;
      end
   end

   assign LOAD_STALL     = load_stall;
   assign MEM_FORWARD_EN = mem_fwd_q;
   assign WB_FORWARD_EN  = wb_fwd_q;

endmodule
